// File: rtl/dma_pkg.sv
// Shared types for the DMA daisy-chain command issuer.
// Defines packet, response and command-entry structs, width constants and FSM states.
// Combinational definitions only; no latency or backpressure of its own.
package dma_pkg;

    localparam int DMA_ID_W  = 3;   // wide enough to carry out-of-range ids for error reporting
    localparam int DMA_ADDR  = 16;
    localparam int DMA_DATA  = 32;
    localparam int DMA_DLY_W = 11;

    typedef struct packed {
        logic                 valid;
        logic [DMA_ID_W-1:0]  id;
        logic [DMA_ADDR-1:0]  addr;
        logic [DMA_DLY_W-1:0] delay;
    } DMA_RPKT;

    typedef struct packed {
        logic                valid;
        logic [DMA_ID_W-1:0] id;
        logic [DMA_ADDR-1:0] addr;
        logic [DMA_DATA-1:0] data;
    } DMA_WPKT;

    typedef struct packed {
        logic                finish;
        logic [DMA_ID_W-1:0] id;
    } DMA_RESP;

    typedef struct packed {
        logic                 write;
        logic [DMA_ID_W-1:0]  id;
        logic [DMA_ADDR-1:0]  addr;
        logic [DMA_DATA-1:0]  data;
        logic [DMA_DLY_W-1:0] delay;
    } DMA_CMD;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BLOCK = 2'd2
    } issue_state_e;

endpackage

// File: rtl/dma_cmd_fifo.sv
// Synchronous FIFO of host command entries with full/empty flags.
// Latency: a pushed entry is visible at head the cycle after the push edge.
// Backpressure: caller must not push when full nor pop when empty.
// Ports: clk, rst (async high), push/push_dat, pop, head, full, empty.
module dma_cmd_fifo
    import dma_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  DMA_CMD push_dat,
    input  logic   pop,
    output DMA_CMD head,
    output logic   full,
    output logic   empty
);
    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty.
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    DMA_CMD      mem_q [DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
    end

    assign head  = mem_q[rd_ptr_q[AW-1:0]];
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/dma_cmd_issuer.sv
// Head-of-chain DMA initiator: buffers host commands, issues one read/write packet per cycle,
// tracks outstanding reads per node and reports completions. Accept->packet latency 2 cycles
// from empty. Backpressure: cmd_ready=!full; a read to a busy node blocks the queue head.
// Ports: clk, rst; cmd_* host command (valid/ready); rpkt_o/wpkt_o to chain head; res_i from
// chain tail; done_valid_o/done_id_o, pending_o, busy_o, err_id_o, err_timeout_o status.
// Optional: define DMA_TIMEOUT_EN to enable the response watchdog (err_timeout_o otherwise 0).
module dma_cmd_issuer
    import dma_pkg::*;
#(
    parameter int NUM_DMA    = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [DMA_ID_W-1:0]  cmd_id,
    input  logic [DMA_ADDR-1:0]  cmd_addr,
    input  logic [DMA_DATA-1:0]  cmd_data,
    input  logic [DMA_DLY_W-1:0] cmd_delay,
    output DMA_RPKT              rpkt_o,
    output DMA_WPKT              wpkt_o,
    input  DMA_RESP              res_i,
    output logic                 done_valid_o,
    output logic [DMA_ID_W-1:0]  done_id_o,
    output logic [NUM_DMA-1:0]   pending_o,
    output logic                 busy_o,
    output logic                 err_id_o,
    output logic                 err_timeout_o
);
    DMA_CMD cmd_in, head;
    logic   fifo_full, fifo_empty, push, pop;

    issue_state_e        state_q, state_d;
    DMA_RPKT             rpkt_q, rpkt_d;
    DMA_WPKT             wpkt_q, wpkt_d;
    logic [NUM_DMA-1:0]  pending_q, pending_d;
    logic                done_valid_q, done_valid_d;
    logic [DMA_ID_W-1:0] done_id_q, done_id_d;
    logic                err_id_q, err_id_d;
    logic                err_to_q, err_to_d;

    // One-hot decodes; an out-of-range id shifts out to all-zero, which doubles as the range check.
    logic [NUM_DMA-1:0] head_oh, res_oh, set_vec, clr_vec;
    logic               head_ok, head_blocked, res_hit, to_clr;

    assign cmd_in = '{write: cmd_write, id: cmd_id, addr: cmd_addr, data: cmd_data, delay: cmd_delay};
    assign cmd_ready = !fifo_full && !rst;
    assign push      = cmd_valid && cmd_ready;

    dma_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (cmd_in),
        .pop      (pop),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign head_oh      = NUM_DMA'(1) << head.id;
    assign head_ok      = |head_oh;
    // Uses registered pending, so a clear landing this edge releases the read next cycle.
    assign head_blocked = !head.write && |(head_oh & pending_q);
    assign res_oh       = res_i.finish ? (NUM_DMA'(1) << res_i.id) : '0;
    assign res_hit      = |(res_oh & pending_q);

`ifdef DMA_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT + 1) > 11) ? $clog2(TIMEOUT + 1) : 11;
    logic [TW-1:0] cnt_q, cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    always_comb begin
        state_d      = state_q;
        pop          = 1'b0;
        rpkt_d       = '0;
        wpkt_d       = '0;
        err_id_d     = 1'b0;
        set_vec      = '0;
        clr_vec      = res_hit ? res_oh : '0;
        done_valid_d = res_hit;
        done_id_d    = res_hit ? res_i.id : done_id_q;
        to_clr       = 1'b0;
        err_to_d     = err_to_q;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) state_d = ISSUE;
            end
            ISSUE, BLOCK: begin
                state_d = ISSUE;
                if (fifo_empty) begin
                    state_d = IDLE;
                end else if (!head_ok) begin
                    pop      = 1'b1;
                    err_id_d = 1'b1;
                end else if (head_blocked) begin
                    state_d = BLOCK;
                end else begin
                    pop = 1'b1;
                    if (head.write) begin
                        wpkt_d = '{valid: 1'b1, id: head.id, addr: head.addr, data: head.data};
                    end else begin
                        rpkt_d  = '{valid: 1'b1, id: head.id, addr: head.addr, delay: head.delay};
                        set_vec = head_oh;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef DMA_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
        if (res_hit || pending_q == '0) begin
            cnt_d = '0;
        end else if (cnt_q == TW'(TIMEOUT - 1)) begin
            cnt_d    = '0;
            err_to_d = 1'b1;
            to_clr   = 1'b1;
        end
`endif

        // Watchdog drops stale reads but keeps a read issued on the same edge.
        pending_d = ((to_clr ? '0 : pending_q) & ~clr_vec) | set_vec;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            rpkt_q       <= '0;
            wpkt_q       <= '0;
            pending_q    <= '0;
            done_valid_q <= 1'b0;
            done_id_q    <= '0;
            err_id_q     <= 1'b0;
            err_to_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            rpkt_q       <= rpkt_d;
            wpkt_q       <= wpkt_d;
            pending_q    <= pending_d;
            done_valid_q <= done_valid_d;
            done_id_q    <= done_id_d;
            err_id_q     <= err_id_d;
            err_to_q     <= err_to_d;
        end
    end

`ifdef DMA_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`endif

    assign rpkt_o        = rpkt_q;
    assign wpkt_o        = wpkt_q;
    assign pending_o     = pending_q;
    assign done_valid_o  = done_valid_q;
    assign done_id_o     = done_id_q;
    assign err_id_o      = err_id_q;
    assign err_timeout_o = err_to_q;
    assign busy_o        = !fifo_empty || (|pending_q);

endmodule
